// File: rtl/servo_pkg.sv
// servo_pkg: shared FSM state type, default parameters and centre-width helper for the servo PWM timebase
package servo_pkg;
  typedef enum logic [1:0] {IDLE, PENDING, SLEWING} state_t;
  localparam int DEF_COUNT_WIDTH  = 12;
  localparam int DEF_PRESCALE_DIV = 244;
  localparam int DEF_MIN_WIDTH    = 205;
  localparam int DEF_MAX_WIDTH    = 410;
  localparam int DEF_SLEW_STEP    = 4;
  function automatic int centre_width(input int lo, input int hi);
    return (lo + hi) / 2;
  endfunction
endpackage

// File: rtl/servo_tick_prescaler.sv
// servo_tick_prescaler: divides the clock down to one tick every PRESCALE_DIV clocks while enabled
module servo_tick_prescaler
  import servo_pkg::*;
#(
  parameter int PRESCALE_DIV = DEF_PRESCALE_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int PW = PRESCALE_DIV > 1 ? $clog2(PRESCALE_DIV) : 1;
  logic [PW-1:0] pre_q, pre_d;
  // tick on the last prescaler count; disabling parks the prescaler at zero
  always_comb begin
    tick  = en && (pre_q == PW'(PRESCALE_DIV - 1));
    pre_d = (!en || tick) ? '0 : pre_q + 1'b1;
  end
  // prescaler register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
endmodule

// File: rtl/servo_pwm_timebase.sv
// servo_pwm_timebase: PWM period counter plus slew-limited pulse-width tracker for hobby servos
module servo_pwm_timebase
  import servo_pkg::*;
#(
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
  parameter int PRESCALE_DIV = DEF_PRESCALE_DIV,
  parameter int MIN_WIDTH    = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH    = DEF_MAX_WIDTH,
  parameter int SLEW_STEP    = DEF_SLEW_STEP
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic                   ENABLE,
  input  logic [COUNT_WIDTH-1:0] POS_DATA,
  input  logic                   POS_VALID,
  output logic                   POS_READY,
  output logic [COUNT_WIDTH-1:0] COUNT_VALUE,
  output logic [COUNT_WIDTH-1:0] PULSE_WIDTH,
  output logic                   PERIOD_START
);
  localparam int XW = COUNT_WIDTH + 1;
  localparam logic [XW-1:0] MIN_W = XW'(MIN_WIDTH);
  localparam logic [XW-1:0] MAX_W = XW'(MAX_WIDTH);
  localparam logic [XW-1:0] STEP  = XW'(SLEW_STEP);
  localparam logic [COUNT_WIDTH-1:0] CENTRE = COUNT_WIDTH'(centre_width(MIN_WIDTH, MAX_WIDTH));

  logic                   tick, boundary, accept, up;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, width_q, width_d, tgt_q, tgt_d;
  logic                   ps_q, ps_d, ready_q, ready_d;
  state_t                 state_q, state_d;
  logic [XW-1:0]          req, clamped, w_ext, t_ext, mag, step, stepped;

  servo_tick_prescaler #(.PRESCALE_DIV(PRESCALE_DIV)) u_prescaler (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .en    (ENABLE),
    .tick  (tick)
  );

  // period counter; the wrap tick is the boundary, flagged in the cycle the count reads zero
  always_comb begin
    boundary = tick && (&cnt_q);
    cnt_d    = !ENABLE ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
    ps_d     = boundary;
  end

  // clamp requests and compute one slew step in XW bits so nothing wraps
  always_comb begin
    req     = {1'b0, POS_DATA};
    clamped = req < MIN_W ? MIN_W : req > MAX_W ? MAX_W : req;
    w_ext   = {1'b0, width_q};
    t_ext   = {1'b0, tgt_q};
    up      = t_ext > w_ext;
    mag     = up ? t_ext - w_ext : w_ext - t_ext;
    step    = mag > STEP ? STEP : mag;
    stepped = up ? w_ext + step : w_ext - step;
  end

  // FSM: width only moves on a boundary, so the comparator sees it change together with PERIOD_START
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    width_d = width_q;
    accept  = POS_VALID && ready_q;
    if (accept) tgt_d = clamped[COUNT_WIDTH-1:0];
    if (state_q == IDLE) begin
      if (accept) state_d = PENDING;
    end else if (boundary) begin
      width_d = stepped[COUNT_WIDTH-1:0];
      state_d = (stepped == (accept ? clamped : t_ext)) ? IDLE : SLEWING;
    end
    ready_d = state_d != PENDING;
  end

  // state registers; reset drops any target and recentres the servo
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      cnt_q   <= '0;
      ps_q    <= 1'b0;
      width_q <= CENTRE;
      tgt_q   <= CENTRE;
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      width_q <= width_d;
      tgt_q   <= tgt_d;
      state_q <= state_d;
      ready_q <= ready_d;
    end

  assign POS_READY    = ready_q;
  assign COUNT_VALUE  = cnt_q;
  assign PULSE_WIDTH  = width_q;
  assign PERIOD_START = ps_q;
endmodule

// File: tb/tb_servo_pwm_timebase.sv
// tb_servo_pwm_timebase: scoreboard bench for the servo PWM timebase with a shortened period
module tb_servo_pwm_timebase;
  localparam int CW  = 9;
  localparam int PER = 1024;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, valid = 1'b0;
  logic [CW-1:0] data = '0;
  logic          ready, ps;
  logic [CW-1:0] cnt, width, prev_w = '0;
  logic          prev_rst = 1'b0;
  int            checks = 0, failures = 0, cyc = 0, last_ps = -1;
  int            exp_q[$];

  servo_pwm_timebase #(.COUNT_WIDTH(CW), .PRESCALE_DIV(2)) dut (
    .CLOCK        (clk),
    .RESET_N      (rst_n),
    .ENABLE       (en),
    .POS_DATA     (data),
    .POS_VALID    (valid),
    .POS_READY    (ready),
    .COUNT_VALUE  (cnt),
    .PULSE_WIDTH  (width),
    .PERIOD_START (ps)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // monitor: boundary widths come from the scoreboard, width must not move elsewhere
  always @(negedge clk) begin
    if (rst_n && prev_rst && en) begin
      if (ps) begin
        if (last_ps >= 0) chk("period_interval", cyc - last_ps, PER);
        last_ps = cyc;
        if (exp_q.size() > 0) chk("boundary_width", int'(width), exp_q.pop_front());
      end else chk("width_stable", int'(width), int'(prev_w));
    end else last_ps = -1;
    prev_w   = width;
    prev_rst = rst_n;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] d);
    int n = 0;
    while (!ready && n < 4 * PER) begin
      step(1);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    data  = d;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 40 * PER) begin
      step(1);
      n++;
    end
    if (exp_q.size() > 0) begin
      chk(name, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    int c0, n;
    step(2);
    chk("rst_width", int'(width), 307);
    chk("rst_count", int'(cnt), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_period_start", int'(ps), 0);
    en    = 1'b1;
    rst_n = 1'b1;
    step(1);
    chk("ready_after_reset", int'(ready), 1);
    c0 = int'(cnt);
    step(2);
    chk("count_step_a", int'(cnt), c0 + 1);
    step(2);
    chk("count_step_b", int'(cnt), c0 + 2);

    send(9'd100);
    chk("pending_ready_low", int'(ready), 0);
    for (int k = 1; k <= 25; k++) exp_q.push_back(307 - 4 * k);
    exp_q.push_back(205);
    exp_q.push_back(205);
    drain("drain_to_min");
    chk("min_idle_ready", int'(ready), 1);
    chk("min_width", int'(width), 205);

    do_reset();
    data  = 9'd511;
    valid = 1'b1;
    step(1);
    for (int k = 1; k <= 25; k++) exp_q.push_back(307 + 4 * k);
    exp_q.push_back(410);
    exp_q.push_back(410);
    step(5);
    chk("held_valid_pending_ready", int'(ready), 0);
    chk("held_valid_width", int'(width), 307);
    n = 0;
    while (!ps && n < PER + 16) begin
      step(1);
      n++;
    end
    chk("first_boundary_seen", int'(ps), 1);
    chk("slew_ready", int'(ready), 1);
    step(1);
    valid = 1'b0;
    drain("drain_to_max");
    chk("max_width", int'(width), 410);

    do_reset();
    send(9'd400);
    exp_q.push_back(311);
    exp_q.push_back(315);
    drain("drain_to_315");
    chk("slewing_ready", int'(ready), 1);
    send(9'd300);
    exp_q.push_back(311);
    exp_q.push_back(307);
    exp_q.push_back(303);
    exp_q.push_back(300);
    exp_q.push_back(300);
    drain("drain_retarget");
    chk("retarget_width", int'(width), 300);

    n = 0;
    while (cnt != 9'd500 && n < 2 * PER) begin
      step(1);
      n++;
    end
    chk("reach_count_500", int'(cnt), 500);
    en = 1'b0;
    step(1);
    chk("disable_count", int'(cnt), 0);
    chk("disable_period_start", int'(ps), 0);
    chk("disable_width", int'(width), 300);
    send(9'd250);
    chk("disabled_accept_ready", int'(ready), 0);
    step(50);
    chk("disabled_hold_count", int'(cnt), 0);
    chk("disabled_hold_width", int'(width), 300);

    en = 1'b1;
    do_reset();
    send(9'd350);
    for (int k = 1; k <= 10; k++) exp_q.push_back(307 + 4 * k);
    exp_q.push_back(350);
    drain("drain_to_350");
    chk("at_350", int'(width), 350);
    send(9'd410);
    step(10);
    rst_n = 1'b0;
    step(1);
    chk("midslew_rst_width", int'(width), 307);
    chk("midslew_rst_count", int'(cnt), 0);
    chk("midslew_rst_ready", int'(ready), 0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_ready", int'(ready), 1);
    exp_q.push_back(307);
    exp_q.push_back(307);
    drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
